// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a shared combinational ALU. A requester's
//   operation is granted in IDLE, driven to the ALU from registers for one
//   EXEC cycle, and the captured result is presented to the granted
//   requester in RESP until that requester accepts it.
//
// Parameters
//   FIXED_PRIO : 0 = round-robin between requesters, 1 = requester 0 always
//                wins when both request.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake (ready is combinational,
//                                 high only in the granting IDLE cycle)
//   reqN_codop/operando1/2        operation fields of requester N
//   respN_valid / respN_ready     result handshake towards requester N
//   resp_resultado, resp_neg,
//   resp_zero, resp_overflow,
//   resp_err                      shared result bus, valid with respN_valid
//   alu_codop, alu_operando1/2    registered drive to the external ALU
//   alu_resultado, alu_neg,
//   alu_zero, alu_overflow        external ALU outputs
//   busy                          high whenever the FSM is not in IDLE
module alu_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_codop,
  input  logic [15:0] req0_operando1,
  input  logic [15:0] req0_operando2,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_codop,
  input  logic [15:0] req1_operando1,
  input  logic [15:0] req1_operando2,

  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,

  output logic [15:0] resp_resultado,
  output logic        resp_neg,
  output logic        resp_zero,
  output logic        resp_overflow,
  output logic        resp_err,

  output logic [3:0]  alu_codop,
  output logic [15:0] alu_operando1,
  output logic [15:0] alu_operando2,

  input  logic [15:0] alu_resultado,
  input  logic        alu_neg,
  input  logic        alu_zero,
  input  logic        alu_overflow,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Lowest illegal codop; codops 13..15 report resp_err.
  localparam logic [3:0] FIRST_ILLEGAL = 4'd13;

  state_t state;
  logic   gid;        // requester owning the operation in flight
  logic   ptr;        // round-robin priority pointer
  logic   any_req;
  logic   grant_sel;  // requester that would be granted this cycle
  logic   accept;
  logic   resp_hs;

  // Grant selection: with both requesting, fixed priority or the pointer
  // decides; with a single requester, that one wins regardless of pointer.
  always_comb begin
    any_req   = req0_valid | req1_valid;
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = (FIXED_PRIO != 0) ? 1'b0 : ptr;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
    // Reset dominates, so no grant is advertised in a reset cycle.
    accept     = (state == IDLE) && any_req && !rst;
    req0_ready = accept && !grant_sel;
    req1_ready = accept &&  grant_sel;
    resp_hs    = (state == RESP) && (gid ? resp1_ready : resp0_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gid            <= 1'b0;
      ptr            <= 1'b0;
      alu_codop      <= '0;
      alu_operando1  <= '0;
      alu_operando2  <= '0;
      resp_resultado <= '0;
      resp_neg       <= 1'b0;
      resp_zero      <= 1'b0;
      resp_overflow  <= 1'b0;
      resp_err       <= 1'b0;
      resp0_valid    <= 1'b0;
      resp1_valid    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gid <= grant_sel;
            if (grant_sel) begin
              alu_codop     <= req1_codop;
              alu_operando1 <= req1_operando1;
              alu_operando2 <= req1_operando2;
            end else begin
              alu_codop     <= req0_codop;
              alu_operando1 <= req0_operando1;
              alu_operando2 <= req0_operando2;
            end
            busy  <= 1'b1;
            state <= EXEC;
          end
        end

        EXEC: begin
          if (alu_codop >= FIRST_ILLEGAL) begin
            // ALU output is meaningless for these codops: report an error
            // with a clean result instead.
            resp_resultado <= '0;
            resp_neg       <= 1'b0;
            resp_zero      <= 1'b0;
            resp_overflow  <= 1'b0;
            resp_err       <= 1'b1;
          end else begin
            resp_resultado <= alu_resultado;
            resp_neg       <= alu_neg;
            resp_zero      <= alu_zero;
            resp_overflow  <= alu_overflow;
            resp_err       <= 1'b0;
          end
          resp0_valid <= ~gid;
          resp1_valid <=  gid;
          state       <= RESP;
        end

        RESP: begin
          if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            // Hand priority to the requester that was not just served.
            ptr         <= ~gid;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench: one instance per arbitration mode (index = FIXED_PRIO)
// sharing the same stimulus. A transaction-level model predicts grants and
// queues the expected response; the monitor compares whenever a response
// is presented.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_codop, req1_codop;
  logic [15:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        resp0_ready, resp1_ready;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic [15:0] rres [2];
  logic        rneg [2];
  logic        rzero[2];
  logic        rovf [2];
  logic        rerr [2];
  logic [3:0]  acod [2];
  logic [15:0] aop1 [2];
  logic [15:0] aop2 [2];
  logic        bsy  [2];

  // Bench-side ALU: {result, neg, zero, overflow}. Codop 12 passes op2 and
  // reports zero from op1, so flag pass-through is visible. Illegal codops
  // return garbage with all flags set.
  function automatic logic [18:0] alu_f(input logic [3:0] c,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic        v, z, n;
    v = 1'b0;
    case (c)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[3:0];
      4'd7: r = a >> b[3:0];
      4'd8: r = a + 16'd1;
      4'd9: r = a - 16'd1;
      4'd10: r = b;
      4'd11: r = {a[7:0], a[15:8]};
      4'd12: r = b;
      default: begin r = 16'hDEAD; v = 1'b1; end
    endcase
    n = r[15];
    z = (c == 4'd12) ? (a == 16'd0) : (r == 16'd0);
    if (c >= 4'd13) begin n = 1'b1; z = 1'b1; end
    return {r, n, z, v};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g
      logic [15:0] ares;
      logic        an, az, av;
      assign {ares, an, az, av} = alu_f(acod[gi], aop1[gi], aop2[gi]);

      alu_arbiter #(.FIXED_PRIO(gi)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (rdy0[gi]),
        .req0_codop     (req0_codop),
        .req0_operando1 (req0_op1),
        .req0_operando2 (req0_op2),
        .req1_valid     (req1_valid),
        .req1_ready     (rdy1[gi]),
        .req1_codop     (req1_codop),
        .req1_operando1 (req1_op1),
        .req1_operando2 (req1_op2),
        .resp0_valid    (rv0[gi]),
        .resp0_ready    (resp0_ready),
        .resp1_valid    (rv1[gi]),
        .resp1_ready    (resp1_ready),
        .resp_resultado (rres[gi]),
        .resp_neg       (rneg[gi]),
        .resp_zero      (rzero[gi]),
        .resp_overflow  (rovf[gi]),
        .resp_err       (rerr[gi]),
        .alu_codop      (acod[gi]),
        .alu_operando1  (aop1[gi]),
        .alu_operando2  (aop2[gi]),
        .alu_resultado  (ares),
        .alu_neg        (an),
        .alu_zero       (az),
        .alu_overflow   (av),
        .busy           (bsy[gi])
      );
    end
  endgenerate

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic        id;
    logic [3:0]  codop;
    logic [15:0] a, b, res;
    logic        n, z, v, err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nmis = 0;

  bit   pending [2];
  int   age     [2];
  logic gidm    [2];
  logic ptrm    [2];
  bit   was_rst [2];

  task automatic chk(input string name, input int i,
                     input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s (FIXED_PRIO=%0d) t=%0t: got %0h expected %0h",
               name, i, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    logic [1:0] rdy, rv, vin, erdy, erv;
    int         g;
    exp_t       e;
    bit         has;
    logic [18:0] f;

    rdy = {rdy1[i], rdy0[i]};
    rv  = {rv1[i], rv0[i]};
    vin = {req1_valid, req0_valid};

    if (was_rst[i]) begin
      chk("reset_outputs", i,
          {5'd0, acod[i], aop1[i], aop2[i], rres[i], rneg[i], rzero[i],
           rovf[i], rerr[i], rv1[i], rv0[i], bsy[i]}, 64'd0);
      was_rst[i] = 1'b0;
    end

    if (rst) begin
      chk("ready_in_reset", i, {62'd0, rdy}, 64'd0);
      pending[i] = 1'b0;
      ptrm[i]    = 1'b0;
      was_rst[i] = 1'b1;
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end

    chk("busy", i, {63'd0, bsy[i]}, {63'd0, pending[i]});
    if (pending[i]) age[i]++;

    erdy = 2'b00;
    g    = -1;
    if (!pending[i]) begin
      if (vin == 2'b11)  g = (i == 1) ? 0 : int'(ptrm[i]);
      else if (vin[0])   g = 0;
      else if (vin[1])   g = 1;
      if (g >= 0) erdy[g] = 1'b1;
    end
    chk("grant", i, {62'd0, rdy}, {62'd0, erdy});

    erv = 2'b00;
    if (pending[i] && age[i] >= 2) erv[gidm[i]] = 1'b1;
    chk("resp_valid", i, {62'd0, rv}, {62'd0, erv});

    has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (pending[i] && has) begin
      e = (i == 0) ? q0[0] : q1[0];
      chk("alu_drive", i, {28'd0, acod[i], aop1[i], aop2[i]},
          {28'd0, e.codop, e.a, e.b});
      if (erv != 2'b00 && rv == erv)
        chk("resp_data", i,
            {44'd0, rres[i], rneg[i], rzero[i], rovf[i], rerr[i]},
            {44'd0, e.res, e.n, e.z, e.v, e.err});
    end

    if (erv != 2'b00 && (gidm[i] ? resp1_ready : resp0_ready)) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      pending[i] = 1'b0;
      ptrm[i]    = ~gidm[i];
    end

    if (g >= 0) begin
      e.id    = g[0];
      e.codop = g[0] ? req1_codop : req0_codop;
      e.a     = g[0] ? req1_op1   : req0_op1;
      e.b     = g[0] ? req1_op2   : req0_op2;
      f = alu_f(e.codop, e.a, e.b);
      if (e.codop >= 4'd13) begin
        e.res = 16'd0; e.n = 1'b0; e.z = 1'b0; e.v = 1'b0; e.err = 1'b1;
      end else begin
        {e.res, e.n, e.z, e.v} = f;
        e.err = 1'b0;
      end
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      pending[i] = 1'b1;
      age[i]     = 0;
      gidm[i]    = g[0];
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drain(input int n);
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_codop = '0; req1_codop = '0;
    req0_op1 = '0; req0_op2 = '0; req1_op1 = '0; req1_op2 = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pending[i] = 1'b0; age[i] = 0; gidm[i] = 1'b0;
      ptrm[i] = 1'b0; was_rst[i] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;

    // signed overflow on add
    req0_valid = 1'b1; req0_codop = 4'd0;
    req0_op1 = 16'h7FFF; req0_op2 = 16'h0001;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();

    // both requesters continuously valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 24; k++) begin
      req0_codop = 4'($urandom_range(0, 12)); req1_codop = 4'($urandom_range(0, 12));
      req0_op1 = rnd16(); req0_op2 = rnd16();
      req1_op1 = rnd16(); req1_op2 = rnd16();
      tick();
    end
    drain(4);

    // pass-through op held while consumer stalls
    req1_valid = 1'b1; req1_codop = 4'd12;
    req1_op1 = 16'h0000; req1_op2 = 16'h1234;
    resp1_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    repeat (7) tick();
    resp1_ready = 1'b1;
    repeat (3) tick();

    // illegal codop
    req0_valid = 1'b1; req0_codop = 4'd14;
    req0_op1 = 16'h5555; req0_op2 = 16'hAAAA;
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();

    // reset while a response is pending
    req0_valid = 1'b1; req0_codop = 4'd1;
    req0_op1 = 16'h0003; req0_op2 = 16'h0005;
    resp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1; resp0_ready = 1'b1;
    tick();
    rst = 1'b0;
    req1_valid = 1'b1; req1_codop = 4'd4;
    req1_op1 = 16'h00FF; req1_op2 = 16'h0F0F;
    tick();
    req1_valid = 1'b0;
    repeat (4) tick();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst         = ($urandom_range(0, 199) == 0);
      req0_valid  = 1'($urandom);
      req1_valid  = 1'($urandom);
      req0_codop  = 4'($urandom);
      req1_codop  = 4'($urandom);
      req0_op1 = rnd16(); req0_op2 = rnd16();
      req1_op1 = rnd16(); req1_op2 = rnd16();
      resp0_ready = ($urandom_range(0, 9) < 7);
      resp1_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  (N=0,1) operation of requester N accepted this cycle.
REQ-006 reqN_codop  in  4;  reqN_operando1  in  16;  reqN_operando2  in  16  (N=0,1) operation fields.
REQ-007 respN_valid  out  1;  respN_ready  in  1  (N=0,1) result handshake per requester.
REQ-008 resp_resultado  out  16;  resp_neg, resp_zero, resp_overflow, resp_err  out  1 each; shared result bus, meaningful only while a respN_valid is high.
REQ-009 alu_codop  out  4;  alu_operando1, alu_operando2  out  16  registered drive to the combinational ALU.
REQ-010 alu_resultado  in  16;  alu_neg, alu_zero, alu_overflow  in  1  ALU outputs.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-013 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle only, register its codop/operands into alu_* regs, record grant id, go EXEC.
REQ-014 Arbitration: both valid -> FIXED_PRIO=1 picks 0; FIXED_PRIO=0 picks requester holding priority pointer; single valid -> that requester regardless of pointer.
REQ-015 Priority pointer moves to the non-granted requester when a response handshake completes; pointer is 0 after reset.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP; at most one reqN_ready high per cycle.
REQ-017 EXEC lasts exactly one cycle: alu_* stable; at its end capture alu_resultado/alu_neg/alu_zero/alu_overflow into resp_* regs, resp_err=0, go RESP.
REQ-018 Codop 13..15 is illegal: accepted normally, ALU result ignored, resp_resultado=0, all flags 0, resp_err=1.
REQ-019 RESP: respN_valid high only for granted N; resp_* held constant; leave to IDLE on the cycle respN_ready=1 is sampled.
REQ-020 Latency: accept at edge T -> respN_valid high from cycle T+2; throughput one op per 3 cycles with ready consumer.
REQ-021 respN_ready of the non-granted requester is ignored; reqN_valid changes during EXEC/RESP are ignored.
REQ-022 No new request accepted in the cycle RESP exits; next acceptance earliest in following IDLE cycle.
REQ-023 Flags passed exactly as ALU presents them during EXEC; no recomputation.

Reset
REQ-024 rst high at an edge -> state IDLE, pointer 0, alu_codop=0, alu_operando1/2=0, resp_* =0, respN_valid=0, reqN_ready=0, busy=0.
REQ-025 rst mid-operation (EXEC or RESP) abandons the operation; no response issued; rst takes priority over all other inputs.

Verification
REQ-026 req0 codop 0, 0x7FFF+0x0001, resp0_ready=1 -> resp0_valid at T+2, resultado 0x8000, neg=1, overflow=1, err=0.
REQ-027 Both valid every cycle, FIXED_PRIO=0, ready=1 -> grants alternate 0,1,0,1; never two readys in one cycle.
REQ-028 Same stimulus, FIXED_PRIO=1 -> only requester 0 granted while req0_valid held.
REQ-029 req1 codop 12, op1=0, op2=0x1234; resp1_ready low 5 cycles -> resp1_valid held, resultado 0x1234, zero=1, constant until ready.
REQ-030 req0 codop 14 -> resp0_valid at T+2, err=1, resultado 0, flags 0.
REQ-031 rst asserted during RESP -> next cycle all outputs at reset values, no resp handshake, subsequent request serviced normally.
